reg_file_2r1w: RTL
==================

Name: reg_file_2r1w

Overview:
Parametrised successor to the 8x16 single-port register file.
- Configurable width and depth.
- Two independent combinational read ports and one synchronous write port.
- Optional same-cycle write-to-read bypass.
- Sequenced bulk-clear engine.
- Sits beside the datapath ALU as the general-purpose register bank. The clear engine lets the controller zero the bank without a reset.

Parameters:
- DATA_W, 16, register width in bits
- DEPTH, 8, number of registers; must be >= 2
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored value only

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- wr_en  in  1  write strobe, sampled on clk rising edge
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  DATA_W  read port B data (combinational)
- clr_req  in  1  single-cycle pulse requesting a bulk clear
- busy  out  1  high while the clear engine runs

Behaviour:
- Reset (asynchronous, active-high):
  - All DEPTH entries go to 0.
  - FSM goes to IDLE, clear counter goes to 0, busy = 0.
  - Read outputs therefore show 0 during reset.
- Write path:
  - In IDLE, if wr_en = 1 and wr_addr < DEPTH, entry[wr_addr] <= wr_data at the rising edge. One-cycle write latency.
  - Writes with wr_addr >= DEPTH are dropped (only possible when DEPTH is not a power of 2).
- Read path:
  - Zero-latency combinational: rd_data_x = entry[rd_addr_x].
  - rd_addr_x >= DEPTH returns 0.
  - A and B are fully independent; both may address the same entry.
- Bypass:
  - Applies when BYPASS = 1, FSM is IDLE, wr_en = 1, wr_addr == rd_addr_x, and the address is in range.
  - In that case rd_data_x = wr_data in the same cycle.
  - BYPASS = 0: stored value is returned until the edge.
- Clear FSM states:
  - IDLE: busy = 0. On clr_req = 1, go to CLEAR with cnt = 0.
  - CLEAR: busy = 1. Each cycle entry[cnt] <= 0 and cnt increments. When cnt == DEPTH-1 the last entry is cleared and the FSM returns to IDLE on that edge. Clear takes exactly DEPTH cycles.
- busy timing: asserts the cycle after clr_req is sampled and deasserts the cycle after the last entry is cleared.
- Simultaneous and boundary cases:
  - clr_req and wr_en in the same IDLE cycle: the write completes, then CLEAR begins next cycle and zeroes that entry too.
  - wr_en during CLEAR: ignored and data lost. The controller must hold off while busy = 1.
  - clr_req during CLEAR: ignored; the sequence does not restart.
  - Reads during CLEAR: return current contents. Already-cleared entries read 0, pending entries read their old value. Bypass is disabled during CLEAR.
  - Reset mid-CLEAR: all entries 0 immediately, FSM goes to IDLE, busy = 0.
- cnt is ADDR_W bits wide. The terminal compare uses DEPTH-1, not wrap-around, so non-power-of-2 depths clear correctly.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to 0 and writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
  - Clear still takes DEPTH cycles.
- Undefined: entry 0 is an ordinary register.

Test Plan:
1. Reset released, write 0x1234 to addr 3, next cycle rd_addr_a = 3, rd_addr_b = 3 -> both read 0x1234; all other addresses read 0x0000.
2. BYPASS = 1: wr_en = 1, wr_addr = 5, wr_data = 0xBEEF, rd_addr_a = 5 in the same cycle -> rd_data_a = 0xBEEF that cycle. Repeat with BYPASS = 0 -> old value 0x0000 that cycle, 0xBEEF next cycle.
3. Fill entries 0..7 with 0x1111*(i+1), pulse clr_req -> busy high for exactly 8 cycles. Mid-clear at cycle 4, entries 0..3 read 0 and entries 4..7 keep their values. After busy falls, all read 0.
4. During CLEAR, assert wr_en to addr 7 with 0xAAAA and pulse clr_req again -> write ignored, no restart, busy falls after the original 8 cycles, entry 7 = 0.
5. Assert reset at CLEAR cycle 2 with entries preloaded -> all outputs 0 and busy = 0 immediately; normal writes work after release.
6. REGFILE_ZERO_REG_EN defined: write 0xFFFF to addr 0 with bypass active -> rd_data_a at addr 0 reads 0x0000 that cycle and after.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: DATA_W x DEPTH register bank, two combinational read ports, one write port, bulk-clear engine.
// Latency: reads 0 cycles (optional same-cycle write bypass), writes 1 cycle, bulk clear exactly DEPTH cycles.
// Backpressure: none; writes and clear requests arriving while busy is high are silently dropped.
// Optional build macro REGFILE_ZERO_REG_EN: entry 0 is hardwired to zero and writes to it are dropped.
module reg_file_2r1w #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              clr_req,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    // Terminal count is DEPTH-1 rather than counter wrap, so odd depths stop correctly.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic wr_accept;
    logic rd_a_ok;
    logic rd_b_ok;

    // A write lands only in IDLE, in range, and not on a hardwired-zero slot.
    assign wr_accept = (state_q == ST_IDLE) && wr_en
                       && ({1'b0, wr_addr} < DEPTH_X)
                       && !(ZERO_REG && (wr_addr == '0));

    assign rd_a_ok = ({1'b0, rd_addr_a} < DEPTH_X) && !(ZERO_REG && (rd_addr_a == '0));
    assign rd_b_ok = ({1'b0, rd_addr_b} < DEPTH_X) && !(ZERO_REG && (rd_addr_b == '0));

    assign busy = (state_q == ST_CLEAR);

    // Next-state for storage, clear sequencer and its counter.
    always_comb begin
        mem_d   = mem_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Write first: a same-cycle clear request still zeroes this entry later.
                if (wr_accept) begin
                    mem_d[wr_addr] = wr_data;
                end
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                mem_d[cnt_q] = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset clears the whole bank at once and aborts any clear in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    // Read port A: stored value, overridden by the in-flight write when bypass is enabled.
    always_comb begin
        rd_data_a = '0;
        if (rd_a_ok) begin
            rd_data_a = mem_q[rd_addr_a];
        end
        if ((BYPASS != 0) && wr_accept && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    // Read port B: identical to port A, fully independent address.
    always_comb begin
        rd_data_b = '0;
        if (rd_b_ok) begin
            rd_data_b = mem_q[rd_addr_b];
        end
        if ((BYPASS != 0) && wr_accept && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule
